// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: pops raw bytes from the receiver FIFO, strips
// E0/F0 prefixes, tracks modifiers and presents one translated key event at a time.
module ps2_scan_decoder #(
    parameter int ERR_W    = 8,
    parameter int CTRL_MAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    output logic             kbd_read_enable,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic [7:0]       ev_ascii,
    output logic             shift,
    output logic             ctrl,
    output logic             caps_lock,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {S_BASE, S_E0, S_F0, S_E0F0} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } ev_t;

    state_t           state_q, state_d;
    ev_t              ev_q, ev_d;
    logic             ev_valid_q, ev_valid_d;
    logic             l_shift_q, l_shift_d;
    logic             r_shift_q, r_shift_d;
    logic             l_ctrl_q, l_ctrl_d;
    logic             r_ctrl_q, r_ctrl_d;
    logic             caps_q, caps_d;
    logic             caps_held_q, caps_held_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic slot_free;
    logic consume;
    logic emit;
    logic err;
    logic cur_ext;
    logic cur_brk;
    logic mod_key;

    function automatic logic is_special(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF) || (b == 8'hAA) || (b == 8'hFA) ||
               (b == 8'hEE) || (b == 8'hFC) || (b == 8'hFD) || (b == 8'hE1);
    endfunction

    // Returns 1..26 for a..z, 0 when the code is not a letter.
    function automatic logic [4:0] letter_idx(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        case (c)
            8'h1C: r = 5'd1;   8'h32: r = 5'd2;   8'h21: r = 5'd3;
            8'h23: r = 5'd4;   8'h24: r = 5'd5;   8'h2B: r = 5'd6;
            8'h34: r = 5'd7;   8'h33: r = 5'd8;   8'h43: r = 5'd9;
            8'h3B: r = 5'd10;  8'h42: r = 5'd11;  8'h4B: r = 5'd12;
            8'h3A: r = 5'd13;  8'h31: r = 5'd14;  8'h44: r = 5'd15;
            8'h4D: r = 5'd16;  8'h15: r = 5'd17;  8'h2D: r = 5'd18;
            8'h1B: r = 5'd19;  8'h2C: r = 5'd20;  8'h3C: r = 5'd21;
            8'h2A: r = 5'd22;  8'h1D: r = 5'd23;  8'h22: r = 5'd24;
            8'h35: r = 5'd25;  8'h1A: r = 5'd26;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // {hit, digit}
    function automatic logic [4:0] digit_idx(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        case (c)
            8'h45: r = {1'b1, 4'd0};  8'h16: r = {1'b1, 4'd1};
            8'h1E: r = {1'b1, 4'd2};  8'h26: r = {1'b1, 4'd3};
            8'h25: r = {1'b1, 4'd4};  8'h2E: r = {1'b1, 4'd5};
            8'h36: r = {1'b1, 4'd6};  8'h3D: r = {1'b1, 4'd7};
            8'h3E: r = {1'b1, 4'd8};  8'h46: r = {1'b1, 4'd9};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] shifted_digit(input logic [3:0] d);
        logic [7:0] r;
        case (d)
            4'd0: r = 8'h29;  4'd1: r = 8'h21;  4'd2: r = 8'h40;
            4'd3: r = 8'h23;  4'd4: r = 8'h24;  4'd5: r = 8'h25;
            4'd6: r = 8'h5E;  4'd7: r = 8'h26;  4'd8: r = 8'h2A;
            4'd9: r = 8'h28;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic sh,
                                            input logic ct, input logic cp);
        logic [4:0] li;
        logic [4:0] dg;
        logic [7:0] r;
        li = letter_idx(c);
        dg = digit_idx(c);
        r  = 8'h00;
        if (li != 5'd0) begin
            if ((CTRL_MAP != 0) && ct) r = {3'b000, li};
            else if (sh ^ cp)          r = 8'h40 + {3'b000, li};
            else                       r = 8'h60 + {3'b000, li};
        end else if (dg[4]) begin
            r = sh ? shifted_digit(dg[3:0]) : (8'h30 + {4'b0000, dg[3:0]});
        end else begin
            case (c)
                8'h29:   r = 8'h20;
                8'h5A:   r = 8'h0D;
                8'h66:   r = 8'h08;
                8'h0D:   r = 8'h09;
                8'h76:   r = 8'h1B;
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    assign slot_free = !ev_valid_q || ev_ready;
    assign consume   = kbd_ready && slot_free;
    assign cur_ext   = (state_q == S_E0) || (state_q == S_E0F0);
    assign cur_brk   = (state_q == S_F0) || (state_q == S_E0F0);
    assign mod_key   = !cur_ext && ((kbd_data == 8'h12) || (kbd_data == 8'h59) ||
                                    (kbd_data == 8'h14));

    always_comb begin
        state_d     = state_q;
        ev_d        = ev_q;
        ev_valid_d  = ev_valid_q;
        l_shift_d   = l_shift_q;
        r_shift_d   = r_shift_q;
        l_ctrl_d    = l_ctrl_q;
        r_ctrl_d    = r_ctrl_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        err_count_d = err_count_q;
        emit        = 1'b0;
        err         = 1'b0;

        if (consume) begin
            if (kbd_data == 8'hE0) begin
                if (state_q == S_BASE) state_d = S_E0;
                else                   err = 1'b1;
            end else if (kbd_data == 8'hF0) begin
                if (state_q == S_BASE)    state_d = S_F0;
                else if (state_q == S_E0) state_d = S_E0F0;
                else                      err = 1'b1;
            end else if (is_special(kbd_data)) begin
                err = 1'b1;
            end else begin
                emit = 1'b1;
            end
        end

        if (err) begin
            state_d = S_BASE;
            if (err_count_q != {ERR_W{1'b1}})
                err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
        end

        if (emit) begin
            state_d    = S_BASE;
            ev_valid_d = 1'b1;
            ev_d.code  = kbd_data;
            ev_d.ext   = cur_ext;
            ev_d.brk   = cur_brk;
            // Translation uses modifier state from before this key's own update.
            ev_d.ascii = (cur_brk || cur_ext || mod_key) ? 8'h00 :
                         to_ascii(kbd_data, l_shift_q | r_shift_q,
                                  l_ctrl_q | r_ctrl_q, caps_q);
            if (!cur_ext && kbd_data == 8'h12) l_shift_d = !cur_brk;
            if (!cur_ext && kbd_data == 8'h59) r_shift_d = !cur_brk;
            if (!cur_ext && kbd_data == 8'h14) l_ctrl_d  = !cur_brk;
            if (cur_ext  && kbd_data == 8'h14) r_ctrl_d  = !cur_brk;
            // caps_held suppresses re-toggling on typematic repeats.
            if (!cur_ext && kbd_data == 8'h58) begin
                if (cur_brk) begin
                    caps_held_d = 1'b0;
                end else begin
                    if (!caps_held_q) caps_d = !caps_q;
                    caps_held_d = 1'b1;
                end
            end
        end else if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_BASE;
            ev_q        <= '0;
            ev_valid_q  <= 1'b0;
            l_shift_q   <= 1'b0;
            r_shift_q   <= 1'b0;
            l_ctrl_q    <= 1'b0;
            r_ctrl_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ev_q        <= ev_d;
            ev_valid_q  <= ev_valid_d;
            l_shift_q   <= l_shift_d;
            r_shift_q   <= r_shift_d;
            l_ctrl_q    <= l_ctrl_d;
            r_ctrl_q    <= r_ctrl_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            err_count_q <= err_count_d;
        end
    end

    // The pop strobe is combinational so the byte is taken in the same cycle.
    assign kbd_read_enable = consume && rst;
    assign ev_valid        = ev_valid_q;
    assign ev_code         = ev_q.code;
    assign ev_ext          = ev_q.ext;
    assign ev_break        = ev_q.brk;
    assign ev_ascii        = ev_q.ascii;
    assign shift           = l_shift_q | r_shift_q;
    assign ctrl            = l_ctrl_q | r_ctrl_q;
    assign caps_lock       = caps_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: a key-level reference model predicts
// events as bytes are queued; a negedge monitor checks what the DUT presents.
module tb_ps2_scan_decoder;
    localparam int ERR_W   = 4;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst;
    logic [7:0]       kbd_data;
    logic             kbd_ready;
    logic             kbd_read_enable;
    logic             ev_valid;
    logic             ev_ready;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_break;
    logic [7:0]       ev_ascii;
    logic             shift;
    logic             ctrl;
    logic             caps_lock;
    logic [ERR_W-1:0] err_count;

    ps2_scan_decoder #(.ERR_W(ERR_W), .CTRL_MAP(1)) dut (
        .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_read_enable(kbd_read_enable), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_ascii(ev_ascii),
        .shift(shift), .ctrl(ctrl), .caps_lock(caps_lock), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       code;
        logic             ext;
        logic             brk;
        logic [7:0]       ascii;
        logic             sh;
        logic             ct;
        logic             cp;
        logic [ERR_W-1:0] err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo[$];
    exp_t       mon_a;
    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int hs    = 0;

    // Reference model: pending prefix flags, set of held keys, caps latch.
    bit m_ext, m_brk, m_caps, m_caps_down;
    bit held[int];
    int m_err;

    logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};
    logic [7:0] digit_shift[10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
        8'h26, 8'h2A, 8'h28};
    logic [7:0] specials[8] = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD, 8'hE1};
    logic [7:0] fixed_codes[5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] fixed_ascii[5] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

    function automatic bit m_shift();
        return held.exists(32'h012) || held.exists(32'h059);
    endfunction

    function automatic bit m_ctrl();
        return held.exists(32'h014) || held.exists(32'h114);
    endfunction

    function automatic logic [7:0] m_ascii(input logic [7:0] c, input bit e, input bit b);
        if (b || e) return 8'h00;
        if (c == 8'h12 || c == 8'h59 || c == 8'h14) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c) begin
                if (m_ctrl()) return 8'(i + 1);
                return (m_shift() ^ m_caps) ? 8'(8'h41 + i) : 8'(8'h61 + i);
            end
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c) return m_shift() ? digit_shift[i] : 8'(8'h30 + i);
        for (int i = 0; i < 5; i++)
            if (fixed_codes[i] == c) return fixed_ascii[i];
        return 8'h00;
    endfunction

    function automatic bit is_special(input logic [7:0] b);
        for (int i = 0; i < 8; i++) if (specials[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_error();
        if (m_err < ERR_MAX) m_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        int   k;
        if (b == 8'hE0) begin
            if (m_ext || m_brk) m_error(); else m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            if (m_brk) m_error(); else m_brk = 1'b1;
        end else if (is_special(b)) begin
            m_error();
        end else begin
            e.ascii = m_ascii(b, m_ext, m_brk);
            k = (m_ext ? 256 : 0) + int'(b);
            if (m_brk) held.delete(k); else held[k] = 1'b1;
            if (b == 8'h58 && !m_ext) begin
                if (!m_brk) begin
                    if (!m_caps_down) m_caps = !m_caps;
                    m_caps_down = 1'b1;
                end else m_caps_down = 1'b0;
            end
            e.code = b;
            e.ext  = m_ext;
            e.brk  = m_brk;
            e.sh   = m_shift();
            e.ct   = m_ctrl();
            e.cp   = m_caps;
            e.err  = ERR_W'(m_err);
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic m_reset();
        m_ext = 0; m_brk = 0; m_caps = 0; m_caps_down = 0; m_err = 0;
        held.delete();
        exp_q.delete();
        fifo.delete();
    endtask

    task automatic refresh();
        kbd_ready = (fifo.size() != 0);
        kbd_data  = kbd_ready ? fifo[0] : 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
        refresh();
    endtask

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // One clock: sample the pop strobe at the edge, then retire the popped byte.
    task automatic tick();
        logic p, r;
        @(posedge clk);
        p = kbd_read_enable;
        r = kbd_ready;
        if (p) begin
            chk("pop_while_empty", int'(r), 1);
            pops++;
        end
        #1;
        if (p && fifo.size() != 0) void'(fifo.pop_front());
        refresh();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input string name, input int lim);
        bit done;
        done = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (fifo.size() == 0 && exp_q.size() == 0 && !ev_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(name, int'(done), 1);
    endtask

    always @(negedge clk) begin
        if (rst && ev_valid) begin
            mon_a = '{ev_code, ev_ext, ev_break, ev_ascii, shift, ctrl, caps_lock, err_count};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got %h want none", mon_a);
            end else begin
                if (mon_a !== exp_q[0]) begin
                    bad++;
                    $display("FAIL event {code,ext,brk,ascii,sh,ct,cp,err}: got %h want %h",
                             mon_a, exp_q[0]);
                end
                if (ev_ready) begin
                    void'(exp_q.pop_front());
                    hs++;
                end
            end
        end
    end

    initial begin
        int p0, h0, r;
        rst = 1'b0;
        ev_ready = 1'b0;
        m_reset();
        fifo.push_back(8'h1C);
        refresh();
        #1;
        chk("rst_ev_valid", int'(ev_valid), 0);
        chk("rst_ev_code", int'(ev_code), 0);
        chk("rst_ev_ascii", int'(ev_ascii), 0);
        chk("rst_flags", int'({ev_ext, ev_break, shift, ctrl, caps_lock}), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_no_pop", int'(kbd_read_enable), 0);
        fifo.delete();
        refresh();
        run(2);
        rst = 1'b1;
        ev_ready = 1'b1;

        p0 = pops;
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain("t1_drain", 50);
        chk("t1_pops", pops - p0, 3);

        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        drain("t2_drain", 50);
        chk("t2_shift", int'(shift), 0);

        send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        drain("t3_drain", 50);
        chk("t3_caps", int'(caps_lock), 1);

        send(8'hE0); send(8'h14); send(8'h21); send(8'hE0); send(8'hF0); send(8'h14);
        drain("t4_drain", 50);
        chk("t4_ctrl", int'(ctrl), 0);

        send(8'hAA); send(8'hE0); send(8'hE0); send(8'hFF); send(8'h1C);
        drain("t5_drain", 50);
        chk("t5_err", int'(err_count), 3);

        // Backpressure: only the first digit may be taken while ev_ready is low.
        send(8'h58); send(8'hF0); send(8'h58);
        drain("caps_off_drain", 50);
        ev_ready = 1'b0;
        p0 = pops;
        h0 = hs;
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        run(10);
        chk("bp_pops", pops - p0, 1);
        chk("bp_valid", int'(ev_valid), 1);
        chk("bp_ascii", int'(ev_ascii), 8'h31);
        ev_ready = 1'b1;
        run(4);
        chk("b2b_handshakes", hs - h0, 4);
        chk("b2b_idle", int'(ev_valid), 0);

        for (int i = 0; i < 400; i++) begin
            ev_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 40)      send(letter_codes[$urandom_range(0, 25)]);
            else if (r < 55) send(digit_codes[$urandom_range(0, 9)]);
            else if (r < 62) send((r % 3 == 0) ? 8'h12 : (r % 3 == 1) ? 8'h59 : 8'h14);
            else if (r < 66) send(8'h58);
            else if (r < 72) send(8'hE0);
            else if (r < 82) send(8'hF0);
            else if (r < 88) send(specials[$urandom_range(0, 7)]);
            else if (r < 92) send(fixed_codes[$urandom_range(0, 4)]);
            else             send(8'($urandom));
            run($urandom_range(0, 2));
        end
        ev_ready = 1'b1;
        drain("rand_drain", 3000);
        chk("rand_err", int'(err_count), m_err);

        // Async reset with an event held and shift down.
        ev_ready = 1'b0;
        send(8'h12);
        run(3);
        chk("pre_rst_shift", int'(shift), 1);
        send(8'h1C); send(8'hF0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", int'(ev_valid), 0);
        chk("async_shift", int'(shift), 0);
        chk("async_err", int'(err_count), 0);
        chk("async_no_pop", int'(kbd_read_enable), 0);
        m_reset();
        refresh();
        run(2);
        rst = 1'b1;
        ev_ready = 1'b1;

        // A pending prefix must not survive reset.
        send(8'hE0); send(8'hF0);
        drain("prefix_drain", 20);
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        refresh();
        run(2);
        rst = 1'b1;
        send(8'h1C);
        drain("post_rst_drain", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
